// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the npc_sel codes, the fetch FSM states, the reset PC and field positions.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_sel_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      VALID = 2'd1,
      ERR   = 2'd2
   } state_t;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int SH_HI  = 10;
   localparam int SH_LO  = 6;
   localparam int FN_HI  = 5;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;
   localparam int TGT_HI = 25;
   localparam int TGT_LO = 0;

   // Branch displacement: sign-extended word offset.
   function automatic logic [31:0] br_ofs(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory req/ack bus.
// master: fetch unit (req, addr out; ack, rdata in). slave: memory.
interface ifetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC select: seq, branch, jump, jump-register.
// In: pc_plus4, npc_sel, br_taken, imm16, target26, jr_addr. Out: next_pc.
module npc_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] jr_addr,
   output logic [31:0] next_pc
);

   always_comb begin
      next_pc = pc_plus4;
      unique case (npc_sel)
         NPC_SEQ: next_pc = pc_plus4;
         NPC_BR: begin
            if (br_taken)
               next_pc = pc_plus4 + br_ofs(imm16);
         end
         NPC_J:   next_pc = {pc_plus4[31:28], target26, 2'b00};
         NPC_JR:  next_pc = jr_addr;
         default: next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch + field split: PC, req/ack fetch FSM, instr register.
// Ports: clk, reset, imem (master), adv/npc_sel/br_taken/jr_addr control,
// instr_valid, instr, pc, pc_plus4, op..target26 fields.
// IFU_ALIGN_CHECK_EN adds misalign_err and a sticky ERR state.
module ifetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
)(
   input  logic         clk,
   input  logic         reset,
   ifetch_unit_if.master imem,
   input  logic         adv,
   input  logic [1:0]   npc_sel,
   input  logic         br_taken,
   input  logic [31:0]  jr_addr,
   output logic         instr_valid,
   output logic [31:0]  instr,
   output logic [31:0]  pc,
   output logic [31:0]  pc_plus4,
   output logic [5:0]   op,
   output logic [5:0]   funct,
   output logic [4:0]   rs,
   output logic [4:0]   rt,
   output logic [4:0]   rd,
   output logic [4:0]   shamt,
   output logic [15:0]  imm16,
   output logic [25:0]  target26
`ifdef IFU_ALIGN_CHECK_EN
   ,
   output logic         misalign_err
`endif
);

   state_t      state, state_n;
   logic [31:0] pc_n, instr_n, next_pc;

`ifdef IFU_ALIGN_CHECK_EN
   logic err_q, err_n;
   assign misalign_err = err_q;
`else
   logic unused_lsb;
   assign unused_lsb = ^next_pc[1:0];
`endif

   assign pc_plus4       = pc + 32'd4;
   assign imem.imem_addr = pc;

   assign op       = instr[OP_HI:OP_LO];
   assign rs       = instr[RS_HI:RS_LO];
   assign rt       = instr[RT_HI:RT_LO];
   assign rd       = instr[RD_HI:RD_LO];
   assign shamt    = instr[SH_HI:SH_LO];
   assign funct    = instr[FN_HI:FN_LO];
   assign imm16    = instr[IMM_HI:IMM_LO];
   assign target26 = instr[TGT_HI:TGT_LO];

   npc_calc u_npc (
      .pc_plus4 (pc_plus4),
      .npc_sel  (npc_sel),
      .br_taken (br_taken),
      .imm16    (imm16),
      .target26 (target26),
      .jr_addr  (jr_addr),
      .next_pc  (next_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
         instr <= '0;
`ifdef IFU_ALIGN_CHECK_EN
         err_q <= 1'b0;
`endif
      end else begin
         state <= state_n;
         pc    <= pc_n;
         instr <= instr_n;
`ifdef IFU_ALIGN_CHECK_EN
         err_q <= err_n;
`endif
      end
   end

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      instr_n       = instr;
      imem.imem_req = 1'b0;
      instr_valid   = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      err_n         = err_q;
`endif
      unique case (state)
         FETCH: begin
            // Drop req the moment reset rises, not at the next edge.
            imem.imem_req = ~reset;
            if (imem.imem_ack) begin
               instr_n = imem.imem_rdata;
               state_n = VALID;
            end
         end
         VALID: begin
            instr_valid = 1'b1;
            if (adv) begin
`ifdef IFU_ALIGN_CHECK_EN
               pc_n = next_pc;
               if (next_pc[1:0] != 2'b00) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else begin
                  state_n = FETCH;
               end
`else
               pc_n    = {next_pc[31:2], 2'b00};
               state_n = FETCH;
`endif
            end
         end
         default: begin
            // ERR: parked until reset.
            state_n = state;
         end
      endcase
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch, stall, all npc_sel paths,
// wrap, reset mid-fetch, misaligned jr.
module tb_ifetch_unit;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic        adv;
   logic [1:0]  npc_sel;
   logic        br_taken;
   logic [31:0] jr_addr;
   logic        instr_valid;
   logic [31:0] instr, pc, pc_plus4;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] target26;
`ifdef IFU_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   ifetch_unit_if bus ();

   ifetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (bus),
      .adv         (adv),
      .npc_sel     (npc_sel),
      .br_taken    (br_taken),
      .jr_addr     (jr_addr),
      .instr_valid (instr_valid),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .op          (op),
      .funct       (funct),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .imm16       (imm16),
      .target26    (target26)
`ifdef IFU_ALIGN_CHECK_EN
      ,
      .misalign_err(misalign_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] word);
      chk("f_req", 32'(bus.imem_req), 32'd1);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      tick();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      chk("f_valid", 32'(instr_valid), 32'd1);
      chk("f_instr", instr, word);
      chk("f_req_lo", 32'(bus.imem_req), 32'd0);
   endtask

   task automatic step(input logic [1:0] sel, input logic bt,
                       input logic [31:0] jr, input logic [31:0] exp);
      npc_sel  = sel;
      br_taken = bt;
      jr_addr  = jr;
      adv      = 1'b1;
      tick();
      adv      = 1'b0;
      chk("adv_req", 32'(bus.imem_req), 32'd1);
      chk("adv_addr", bus.imem_addr, exp);
      chk("adv_valid", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      adv            = 1'b0;
      npc_sel        = NPC_SEQ;
      br_taken       = 1'b0;
      jr_addr        = '0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      repeat (2) tick();
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_instr", instr, 32'd0);
`ifdef IFU_ALIGN_CHECK_EN
      chk("rst_err", 32'(misalign_err), 32'd0);
`endif
      reset = 1'b0;
      #1;
      chk("rel_req", 32'(bus.imem_req), 32'd1);
      chk("rel_addr", bus.imem_addr, 32'h0000_3000);
      chk("rel_valid", 32'(instr_valid), 32'd0);

      // lui $1,0x1234
      fetch(32'h3C01_1234);
      chk("lui_op", 32'(op), 32'h0F);
      chk("lui_rs", 32'(rs), 32'd0);
      chk("lui_rt", 32'(rt), 32'd1);
      chk("lui_imm", 32'(imm16), 32'h1234);
      chk("lui_pc", pc, 32'h0000_3000);
      chk("lui_pc4", pc_plus4, 32'h0000_3004);

      // Stall with spurious acks: must hold.
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hFFFF_FFFF;
      repeat (3) tick();
      bus.imem_ack   = 1'b0;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h3C01_1234);
      chk("stall_req", 32'(bus.imem_req), 32'd0);

      step(NPC_SEQ, 1'b0, 32'd0, 32'h0000_3004);

      // beq, offset -1 word: taken -> 0x3008-4
      fetch(32'h1000_FFFF);
      chk("br_imm", 32'(imm16), 32'h0000_FFFF);
      step(NPC_BR, 1'b1, 32'd0, 32'h0000_3004);
      fetch(32'h1000_FFFF);
      step(NPC_BR, 1'b0, 32'd0, 32'h0000_3008);

      fetch(32'h0);
      step(NPC_SEQ, 1'b0, 32'd0, 32'h0000_300C);
      fetch(32'h0);
      step(NPC_SEQ, 1'b0, 32'd0, 32'h0000_3010);

      // j 0xC40 at 0x3010 -> 0x3100; br_taken must not matter
      fetch(32'h0800_0C40);
      chk("j_tgt", 32'(target26), 32'h0000_0C40);
      chk("j_op", 32'(op), 32'h02);
      step(NPC_J, 1'b1, 32'hFFFF_FFF0, 32'h0000_3100);

      // jr $31
      fetch(32'h03E0_0008);
      chk("jr_rs", 32'(rs), 32'd31);
      chk("jr_funct", 32'(funct), 32'h08);
      step(NPC_JR, 1'b0, 32'h0040_0020, 32'h0040_0020);

      // sll $2,$3,5; then forward branch +0x1140 words
      fetch(32'h0003_1140);
      chk("sll_rt", 32'(rt), 32'd3);
      chk("sll_rd", 32'(rd), 32'd2);
      chk("sll_sh", 32'(shamt), 32'd5);
      step(NPC_BR, 1'b1, 32'd0, 32'h0040_4524);

      // add $8,$9,$10
      fetch(32'h012A_4020);
      chk("add_rs", 32'(rs), 32'd9);
      chk("add_rt", 32'(rt), 32'd10);
      chk("add_rd", 32'(rd), 32'd8);
      chk("add_funct", 32'(funct), 32'h20);
      step(NPC_JR, 1'b0, 32'h4000_0000, 32'h4000_0000);

      // j keeps pc_plus4[31:28]
      fetch(32'h0800_0010);
      step(NPC_J, 1'b0, 32'd0, 32'h4000_0040);

      // wrap at top of address space
      fetch(32'h0);
      step(NPC_JR, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      fetch(32'h0);
      chk("wrap_pc4", pc_plus4, 32'h0);
      step(NPC_SEQ, 1'b0, 32'd0, 32'h0);

      // reset mid-fetch; ack arrives while reset is high
      chk("mid_req", 32'(bus.imem_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_req_drop", 32'(bus.imem_req), 32'd0);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hAAAA_5555;
      tick();
      reset        = 1'b0;
      bus.imem_ack = 1'b0;
      #1;
      chk("mid_pc", pc, 32'h0000_3000);
      chk("mid_valid", 32'(instr_valid), 32'd0);
      chk("mid_instr", instr, 32'd0);
      repeat (3) tick();
      chk("mid_wait", 32'(instr_valid), 32'd0);
      chk("mid_req2", 32'(bus.imem_req), 32'd1);
      fetch(32'h2401_0007);

      // misaligned jr target
      npc_sel = NPC_JR;
      jr_addr = 32'h0000_3002;
      adv     = 1'b1;
      tick();
      adv     = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      chk("mis_err", 32'(misalign_err), 32'd1);
      chk("mis_req", 32'(bus.imem_req), 32'd0);
      chk("mis_valid", 32'(instr_valid), 32'd0);
      chk("mis_pc", pc, 32'h0000_3002);
      bus.imem_ack = 1'b1;
      adv          = 1'b1;
      repeat (3) tick();
      bus.imem_ack = 1'b0;
      adv          = 1'b0;
      chk("mis_sticky", 32'(misalign_err), 32'd1);
      chk("mis_req2", 32'(bus.imem_req), 32'd0);
      chk("mis_valid2", 32'(instr_valid), 32'd0);
`else
      chk("mis_pc", pc, 32'h0000_3000);
      chk("mis_req", 32'(bus.imem_req), 32'd1);
      chk("mis_addr", bus.imem_addr, 32'h0000_3000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
